// File: rtl/sequenciador_tx_uart.sv
// Message sequencer for a byte-wide UART transmitter.
// Bytes are queued in a small circular buffer while idle; on iniciar they are
// handed one at a time to the UART (load, start pulse, wait for pronto_uart),
// with GAP idle cycles between bytes. Optional macro SEQ_CHECKSUM_EN appends the
// XOR of all transmitted bytes as a trailing byte.
module sequenciador_tx_uart #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       escreve,
    input  logic [7:0] dado,
    input  logic       iniciar,
    input  logic       pronto_uart,
    output logic       partida_uart,
    output logic [7:0] dados_uart,
    output logic       cheio,
    output logic       ocupado,
    output logic       fim,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        CARREGA   = 4'd1,
        PARTIDA   = 4'd2,
        ESPERA    = 4'd3,
        INTERVALO = 4'd4,
        CHECKSUM  = 4'd5,
        FINAL     = 4'd6
    } estado_t;

    estado_t       estado_q;
    logic [7:0]    buffer [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [GW-1:0] gap_q;
    logic          wr_ok;
`ifdef SEQ_CHECKSUM_EN
    logic [7:0]    checksum_q;
    logic          envia_chk_q;  // the byte in flight is the checksum
`endif

    // Writes are only accepted while idle and not full.
    assign wr_ok     = (estado_q == OCIOSO) && escreve && !cheio;
    assign cheio     = (count_q == CW'(DEPTH));
    assign ocupado   = (estado_q != OCIOSO);
    assign db_estado = estado_q;

    // Message storage; no reset needed since count_q gates what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            buffer[wr_ptr_q] <= dado;
        end
    end

    // Sequencer FSM with registered UART handshake and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            partida_uart <= 1'b0;
            dados_uart   <= 8'h00;
            fim          <= 1'b0;
            erro         <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            checksum_q   <= 8'h00;
            envia_chk_q  <= 1'b0;
`endif
        end else begin
            partida_uart <= 1'b0;
            fim          <= 1'b0;
            unique case (estado_q)
                OCIOSO: begin
                    if (wr_ok) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        count_q  <= count_q + CW'(1);
                    end
                    if (iniciar) begin
                        erro <= 1'b0;
                        // A byte written in this same cycle joins the message.
                        if (count_q != '0 || wr_ok) begin
                            estado_q <= CARREGA;
                        end else begin
                            estado_q <= FINAL;
                            fim      <= 1'b1;
                        end
                    end
                end
                CARREGA: begin
                    dados_uart   <= buffer[rd_ptr_q];
`ifdef SEQ_CHECKSUM_EN
                    checksum_q   <= checksum_q ^ buffer[rd_ptr_q];
`endif
                    partida_uart <= 1'b1;
                    estado_q     <= PARTIDA;
                end
                PARTIDA: begin
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    if (pronto_uart) begin
`ifdef SEQ_CHECKSUM_EN
                        if (envia_chk_q) begin
                            envia_chk_q <= 1'b0;
                            estado_q    <= FINAL;
                            fim         <= 1'b1;
                        end else begin
`endif
                            count_q  <= count_q - CW'(1);
                            rd_ptr_q <= rd_ptr_q + PW'(1);
                            if (count_q > CW'(1)) begin
                                if (GAP == 0) begin
                                    estado_q <= CARREGA;
                                end else begin
                                    estado_q <= INTERVALO;
                                    gap_q    <= '0;
                                end
                            end else begin
`ifdef SEQ_CHECKSUM_EN
                                estado_q <= CHECKSUM;
`else
                                estado_q <= FINAL;
                                fim      <= 1'b1;
`endif
                            end
`ifdef SEQ_CHECKSUM_EN
                        end
`endif
                    end
                end
                INTERVALO: begin
                    if (gap_q == GW'(GAP - 1)) begin
                        estado_q <= CARREGA;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
`ifdef SEQ_CHECKSUM_EN
                CHECKSUM: begin
                    dados_uart   <= checksum_q;
                    partida_uart <= 1'b1;
                    envia_chk_q  <= 1'b1;
                    estado_q     <= PARTIDA;
                end
`endif
                FINAL: begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
`ifdef SEQ_CHECKSUM_EN
                    checksum_q <= 8'h00;
`endif
                    estado_q <= OCIOSO;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
            // Any write that was not accepted flags an error; wins over a clear.
            if (escreve && !wr_ok) begin
                erro <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sequenciador_tx_uart.sv
// Bench for sequenciador_tx_uart: message-level model (buffer queue, expected
// byte queue, outstanding byte count) plus a UART responder that answers each
// start pulse with pronto_uart after uart_delay cycles.
module tb_sequenciador_tx_uart;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;
`ifdef SEQ_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       escreve = 1'b0;
    logic [7:0] dado = 8'h00;
    logic       iniciar = 1'b0;
    logic       pronto_uart = 1'b0;
    logic       partida_uart;
    logic [7:0] dados_uart;
    logic       cheio;
    logic       ocupado;
    logic       fim;
    logic       erro;
    logic [3:0] db_estado;

    sequenciador_tx_uart #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .escreve      (escreve),
        .dado         (dado),
        .iniciar      (iniciar),
        .pronto_uart  (pronto_uart),
        .partida_uart (partida_uart),
        .dados_uart   (dados_uart),
        .cheio        (cheio),
        .ocupado      (ocupado),
        .fim          (fim),
        .erro         (erro),
        .db_estado    (db_estado)
    );

    always #10 clock = ~clock;

    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    logic [7:0] buf_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    int         part_cyc[$];
    int         rem = 0;
    bit         busy = 0;
    bit         exp_erro = 0;
    bit         in_flight = 0;
    bit         prev_part = 0;
    int         pronto_due = 0;
    int         uart_delay = 100;
    logic [7:0] held = 8'h00;
    int         fim_cnt = 0;
    int         fim_cyc = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Per-cycle comparison against the model; also plays the UART.
    task automatic mon();
        logic [7:0] e;
        chk("ocupado", ocupado, busy);
        chk("cheio", cheio, (buf_q.size() + rem) == DEPTH);
        chk("erro", erro, exp_erro);
        if (partida_uart) begin
            chk("partida_single", prev_part, 0);
            chk("partida_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("partida_byte", dados_uart, e);
            end
            tx_log.push_back(dados_uart);
            part_cyc.push_back(cyc);
            held = dados_uart;
            in_flight = 1;
            pronto_due = cyc + uart_delay;
        end else if (in_flight) begin
            chk("dados_stable", dados_uart, held);
        end
        prev_part = partida_uart;
        pronto_uart = 1'b0;
        if (in_flight && cyc == pronto_due) begin
            pronto_uart = 1'b1;
            in_flight = 0;
            if (rem > 0) rem--;
        end
        if (fim) begin
            fim_cnt++;
            fim_cyc = cyc;
            chk("fim_all_sent", exp_q.size() + rem + int'(in_flight), 0);
            busy = 0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        mon();
    endtask

    task automatic write_byte(input logic [7:0] b);
        escreve = 1'b1;
        dado = b;
        if (!busy && buf_q.size() < DEPTH) buf_q.push_back(b);
        else exp_erro = 1;
        step();
        escreve = 1'b0;
    endtask

    task automatic start_msg(output int n);
        logic [7:0] x;
        n = cyc;
        iniciar = 1'b1;
        exp_erro = 0;
        busy = 1;
        if (buf_q.size() > 0) begin
            x = 8'h00;
            rem = buf_q.size();
            foreach (buf_q[i]) begin
                exp_q.push_back(buf_q[i]);
                x ^= buf_q[i];
            end
            if (CHK == 1) exp_q.push_back(x);
            buf_q.delete();
        end
        step();
        iniciar = 1'b0;
    endtask

    task automatic wait_fim(input int bound);
        int f0;
        f0 = fim_cnt;
        for (int i = 0; i < bound && fim_cnt == f0; i++) step();
        chk("fim_arrives", fim_cnt != f0, 1);
    endtask

    task automatic wait_state(input logic [3:0] code, input int bound);
        for (int i = 0; i < bound && db_estado != code; i++) step();
        chk("reach_state", db_estado, code);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_partida", partida_uart, 0);
        chk("rst_dados", dados_uart, 8'h00);
        chk("rst_cheio", cheio, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_fim", fim, 0);
        chk("rst_erro", erro, 0);
        chk("rst_estado", db_estado, 4'h0);
    endtask

    initial begin
        int n, p0, f0, pc;
        #1 reset = 1'b1;
        #4 chk_reset_outputs();
        step();
        step();
        reset = 1'b0;
        step();

        // Two-byte message, 100-cycle UART.
        uart_delay = 100;
        write_byte(8'hB5);
        write_byte(8'hD5);
        p0 = part_cyc.size();
        f0 = fim_cnt;
        start_msg(n);
        wait_fim(2000);
        for (int i = 0; i < 5; i++) step();
        chk("lat_iniciar_partida", part_cyc[p0] - n, 2);
        chk("partida_spacing", part_cyc[p0 + 1] - part_cyc[p0], 106);
        chk("byte0_b5", tx_log[p0], 8'hB5);
        chk("byte1_d5", tx_log[p0 + 1], 8'hD5);
        chk("partidas_msg1", part_cyc.size() - p0, 2 + CHK);
        chk("one_fim_msg1", fim_cnt - f0, 1);
        if (CHK == 1) chk("checksum_60", tx_log[p0 + 2], 8'h60);

        // Empty message: fim at N+1, no UART traffic.
        pc = part_cyc.size();
        start_msg(n);
        chk("empty_fim_n1", fim, 1);
        chk("empty_fim_cycle", fim_cyc, n + 1);
        chk("empty_state_final", db_estado, 4'h6);
        step();
        chk("empty_fim_pulse", fim, 0);
        chk("empty_state_idle", db_estado, 4'h0);
        for (int i = 0; i < 5; i++) step();
        chk("empty_no_partida", part_cyc.size() - pc, 0);

        // Overfill: nine writes into eight entries.
        uart_delay = 10;
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        chk("cheio_after_8", cheio, 1);
        chk("erro_before_9", erro, 0);
        write_byte(8'h09);
        chk("erro_after_9", erro, 1);
        p0 = part_cyc.size();
        start_msg(n);
        chk("erro_cleared", erro, 0);
        wait_fim(2000);
        step();
        chk("full_count", part_cyc.size() - p0, 8 + CHK);
        chk("full_last_data", tx_log[p0 + 7], 8'h08);
        chk("cheio_after_msg", cheio, 0);

        // FE, FF, B5 (checksum B4 when enabled).
        write_byte(8'hFE);
        write_byte(8'hFF);
        write_byte(8'hB5);
        p0 = part_cyc.size();
        start_msg(n);
        wait_fim(2000);
        step();
        chk("fe_ff_b5_count", part_cyc.size() - p0, 3 + CHK);
        chk("fe_ff_b5_last", tx_log[tx_log.size() - 1], (CHK == 1) ? 8'hB4 : 8'hB5);

        // Reset while waiting for pronto of the 2nd of 3 bytes.
        uart_delay = 50;
        write_byte(8'h21);
        write_byte(8'h22);
        write_byte(8'h23);
        p0 = part_cyc.size();
        start_msg(n);
        for (int i = 0; i < 500 && part_cyc.size() < p0 + 2; i++) step();
        chk("second_partida_seen", part_cyc.size() - p0, 2);
        for (int i = 0; i < 5; i++) step();
        chk("in_espera", db_estado, 4'h3);
        chk("dados_second", dados_uart, 8'h22);
        reset = 1'b1;
        #1 chk_reset_outputs();
        exp_q.delete();
        buf_q.delete();
        rem = 0;
        busy = 0;
        exp_erro = 0;
        in_flight = 0;
        prev_part = 0;
        f0 = fim_cnt;
        pc = part_cyc.size();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 80; i++) step();
        chk("no_fim_after_reset", fim_cnt - f0, 0);
        chk("no_partida_after_reset", part_cyc.size() - pc, 0);
        write_byte(8'h5A);
        p0 = part_cyc.size();
        start_msg(n);
        wait_fim(2000);
        step();
        chk("post_reset_byte", tx_log[p0], 8'h5A);
        chk("post_reset_count", part_cyc.size() - p0, 1 + CHK);

        // Write and stray pronto during INTERVALO.
        uart_delay = 20;
        write_byte(8'h31);
        write_byte(8'h32);
        p0 = part_cyc.size();
        start_msg(n);
        wait_state(4'h4, 500);
        escreve = 1'b1;
        dado = 8'h11;
        pronto_uart = 1'b1;
        exp_erro = 1;
        step();
        escreve = 1'b0;
        chk("erro_busy_write", erro, 1);
        wait_fim(2000);
        step();
        chk("gap_msg_count", part_cyc.size() - p0, 2 + CHK);
        chk("gap_msg_byte1", tx_log[p0 + 1], 8'h32);
        pc = part_cyc.size();
        start_msg(n);
        chk("buffer_empty_after", fim, 1);
        for (int i = 0; i < 5; i++) step();
        chk("no_stray_byte", part_cyc.size() - pc, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
